// File: rtl/pio_pattern_sequencer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state encoding for the PIO pattern sequencer.
// Pure declarations: no latency or backpressure of its own.
package pio_pattern_sequencer_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_PERIOD = 4'd2;
    localparam logic [3:0] ADDR_LENGTH = 4'd3;
    localparam int         PAT_ADDR_BIT = 3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_LOOP   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    function automatic logic length_ok(input logic [3:0] len);
        return (len != 4'd0) && (len <= 4'd8);
    endfunction

endpackage

// File: rtl/pio_pattern_sequencer_regfile.sv
// Avalon-MM slave decode, PATTERN array and config registers; reads are zero-wait combinational, writes land on the next edge.
// CTRL START/STOP and STATUS DONE-clear leave as single-cycle pulses; PIO_SEQ_IRQ_EN adds the stored IRQ_EN bit.
module pio_seq_regfile
    import pio_pattern_sequencer_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int PAT_DEPTH = 8,
    parameter int PERIOD_W  = 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    s_address,
    input  logic                          s_chipselect,
    input  logic                          s_write_n,
    input  logic [31:0]                   s_writedata,
    output logic [31:0]                   s_readdata,
    input  logic                          busy,
    input  logic                          done,
    input  logic [2:0]                    idx,
    output logic                          start,
    output logic                          stop,
    output logic                          done_clr,
    output logic                          loop,
`ifdef PIO_SEQ_IRQ_EN
    output logic                          irq_en,
`endif
    output logic [PERIOD_W-1:0]           period,
    output logic [3:0]                    length,
    output logic [PAT_DEPTH*DATA_W-1:0]   pattern_flat
);

    logic [DATA_W-1:0] pattern [PAT_DEPTH];
    logic              wr;
    logic              ctrl_wr;
    logic              unused_wdata;

    assign wr           = s_chipselect && !s_write_n;
    assign ctrl_wr      = wr && (s_address == ADDR_CTRL);
    assign unused_wdata = ^s_writedata;

    // STOP dominates a simultaneous START.
    assign start    = ctrl_wr && s_writedata[CTRL_START] && !s_writedata[CTRL_STOP];
    assign stop     = ctrl_wr && s_writedata[CTRL_STOP];
    assign done_clr = wr && (s_address == ADDR_STATUS) && s_writedata[STAT_DONE];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop   <= 1'b0;
`ifdef PIO_SEQ_IRQ_EN
            irq_en <= 1'b0;
`endif
            period <= '0;
            length <= '0;
            for (int i = 0; i < PAT_DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr) begin
            if (s_address == ADDR_CTRL) begin
                loop   <= s_writedata[CTRL_LOOP];
`ifdef PIO_SEQ_IRQ_EN
                irq_en <= s_writedata[CTRL_IRQ_EN];
`endif
            end
            if (s_address == ADDR_PERIOD) begin
                period <= s_writedata[PERIOD_W-1:0];
            end
            // LENGTH is frozen while a sequence runs so the end-of-sequence compare stays coherent.
            if (s_address == ADDR_LENGTH && !busy) begin
                length <= s_writedata[3:0];
            end
            if (s_address[PAT_ADDR_BIT]) begin
                pattern[s_address[2:0]] <= s_writedata[DATA_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < PAT_DEPTH; g++) begin : g_flat
        assign pattern_flat[g*DATA_W +: DATA_W] = pattern[g];
    end

    always_comb begin
        s_readdata = '0;
        if (s_address[PAT_ADDR_BIT]) begin
            s_readdata[DATA_W-1:0] = pattern[s_address[2:0]];
        end else begin
            case (s_address)
                ADDR_CTRL: begin
                    s_readdata[CTRL_LOOP] = loop;
`ifdef PIO_SEQ_IRQ_EN
                    s_readdata[CTRL_IRQ_EN] = irq_en;
`endif
                end
                ADDR_STATUS: begin
                    s_readdata[STAT_BUSY]           = busy;
                    s_readdata[STAT_DONE]           = done;
                    s_readdata[STAT_IDX_LSB +: 3]   = idx;
                end
                ADDR_PERIOD: s_readdata[PERIOD_W-1:0] = period;
                ADDR_LENGTH: s_readdata[3:0]          = length;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pio_pattern_sequencer.sv
// Plays PATTERN[0..LENGTH-1] into a PIO data register, one Avalon-MM write per step, dwelling PERIOD cycles between steps.
// m_write is held with stable data until m_waitrequest drops; the dwell starts only after acceptance. PIO_SEQ_IRQ_EN adds irq.
module pio_pattern_sequencer
    import pio_pattern_sequencer_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int PAT_DEPTH = 8,
    parameter int PERIOD_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef PIO_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    state_t                      state;
    logic [2:0]                  idx;
    logic [2:0]                  idx_inc;
    logic [PERIOD_W-1:0]         cnt;
    logic [PERIOD_W-1:0]         period;
    logic [3:0]                  length;
    logic [PAT_DEPTH*DATA_W-1:0] pattern_flat;
    logic [DATA_W-1:0]           pat [PAT_DEPTH];
    logic                        busy;
    logic                        done;
    logic                        done_nxt;
    logic                        stop_pend;
    logic                        loop;
    logic                        start;
    logic                        stop;
    logic                        done_clr;
    logic                        start_ok;
    logic                        dwell_end;
    logic                        at_last;
    logic                        done_set;
`ifdef PIO_SEQ_IRQ_EN
    logic                        irq_en;
`endif

    pio_seq_regfile #(
        .DATA_W    (DATA_W),
        .PAT_DEPTH (PAT_DEPTH),
        .PERIOD_W  (PERIOD_W)
    ) u_regfile (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .busy         (busy),
        .done         (done),
        .idx          (idx),
        .start        (start),
        .stop         (stop),
        .done_clr     (done_clr),
        .loop         (loop),
`ifdef PIO_SEQ_IRQ_EN
        .irq_en       (irq_en),
`endif
        .period       (period),
        .length       (length),
        .pattern_flat (pattern_flat)
    );

    for (genvar g = 0; g < PAT_DEPTH; g++) begin : g_pat
        assign pat[g] = pattern_flat[g*DATA_W +: DATA_W];
    end

    assign m_address = 2'b00;
    assign busy      = (state != ST_IDLE);
    assign idx_inc   = idx + 3'd1;
    assign start_ok  = (state == ST_IDLE) && start && length_ok(length);
    assign dwell_end = (state == ST_DWELL) && !stop && (cnt <= CNT_ONE);
    assign at_last   = ({1'b0, idx} == (length - 4'd1));
    assign done_set  = dwell_end && at_last && !loop;

    always_comb begin
        done_nxt = done;
        if (done_clr || start_ok) begin
            done_nxt = 1'b0;
        end
        if (done_set) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= done_nxt;
        end
    end

`ifdef PIO_SEQ_IRQ_EN
    // Built from done_nxt so irq rises and falls on the same edge as DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= done_nxt && irq_en;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            cnt         <= '0;
            m_write     <= 1'b0;
            m_writedata <= '0;
            stop_pend   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_ok) begin
                        idx         <= 3'd0;
                        state       <= ST_WRITE;
                        m_write     <= 1'b1;
                        m_writedata <= 32'(pat[0]);
                    end
                end
                ST_WRITE: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (!m_waitrequest) begin
                        m_write <= 1'b0;
                        if (stop || stop_pend) begin
                            state     <= ST_IDLE;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= ST_DWELL;
                            cnt   <= (period == '0) ? CNT_ONE : period;
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (cnt <= CNT_ONE) begin
                        cnt <= '0;
                        if (at_last && !loop) begin
                            state <= ST_IDLE;
                        end else begin
                            idx         <= at_last ? 3'd0 : idx_inc;
                            state       <= ST_WRITE;
                            m_write     <= 1'b1;
                            m_writedata <= 32'(at_last ? pat[0] : pat[idx_inc]);
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    m_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
